// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for the successive-approximation search controller.
// The controller (master) drives the trial operand and status. The comparator
// and requester side (slave) returns the eq/gt/lt flags and the start request.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start, cmp_eq, cmp_gt, cmp_lt,
        output trial, busy, done, result, err
    );

    modport slave (
        output start, cmp_eq, cmp_gt, cmp_lt,
        input  trial, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller.
// It drives the b operand (trial) of an external magnitude comparator and
// recovers the comparator's a value one bit at a time, starting at the MSB.
// CMP_LAT adds settle cycles after each trial update, before the flags are sampled.
// Optional build macro SAR_EARLY_EXIT_EN: a valid cmp_eq in TRY ends the
// search at once, and the current trial becomes the result.
module sar_search_ctrl #(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    sar_search_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRY,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int               KW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int               CW         = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [CW-1:0]    CNT_RELOAD = (CMP_LAT > 0) ? CW'(CMP_LAT - 1) : '0;
    localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [KW-1:0]    K_INIT     = KW'(WIDTH - 1);
    // Every trial update goes through WAIT when the comparator needs settle time.
    localparam state_t           ARM_STATE  = (CMP_LAT > 0) ? S_WAIT : S_TRY;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             flags_ok;
    logic             keep_bit;
    logic [WIDTH-1:0] decided;

    // Decide the current bit from the flags, and compute the next state and registers.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_d  = state_q;
        trial_d  = trial_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        // An illegal flag combination counts as "a < trial", so the bit is cleared.
        flags_ok     = $onehot({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt});
        keep_bit     = flags_ok && (bus.cmp_gt || bus.cmp_eq);
        decided      = trial_q;
        decided[k_q] = keep_bit;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = ARM_STATE;
                    trial_d = TRIAL_INIT;
                    k_d     = K_INIT;
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_TRY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_TRY: begin
                if (!flags_ok) begin
                    err_d = 1'b1;
                end
`ifdef SAR_EARLY_EXIT_EN
                if (flags_ok && bus.cmp_eq) begin
                    result_d = trial_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else
`endif
                if (k_q != '0) begin
                    trial_d              = decided;
                    trial_d[k_q - 1'b1]  = 1'b1;
                    k_d                  = k_q - 1'b1;
                    cnt_d                = CNT_RELOAD;
                    state_d              = ARM_STATE;
                end else begin
                    trial_d  = decided;
                    result_d = decided;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
        if (rst) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl.
// Two instances are tested: one with a combinational comparator (CMP_LAT=0)
// and one with CMP_LAT=2. A search-level model predicts every output on every
// cycle, and literal checks pin the model on hand-worked cases.
module tb_sar_search_ctrl;

    localparam int W = 4;
    localparam logic [W-1:0] TOP = W'(1) << (W - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sar_search_ctrl_if #(.WIDTH(W)) if0 ();
    sar_search_ctrl_if #(.WIDTH(W)) if2 ();

    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int lat [2] = '{0, 2};

    logic         start_r     [2];
    logic [W-1:0] a_val       [2];
    logic         force_first [2];

    logic [W-1:0] trial_o  [2];
    logic [W-1:0] result_o [2];
    logic         busy_o   [2];
    logic         done_o   [2];
    logic         err_o    [2];

    assign if0.start = start_r[0];
    assign if2.start = start_r[1];
    assign trial_o[0] = if0.trial;   assign trial_o[1] = if2.trial;
    assign result_o[0] = if0.result; assign result_o[1] = if2.result;
    assign busy_o[0] = if0.busy;     assign busy_o[1] = if2.busy;
    assign done_o[0] = if0.done;     assign done_o[1] = if2.done;
    assign err_o[0] = if0.err;       assign err_o[1] = if2.err;

    // Comparator model: eq/gt/lt from a and trial; a forced gt+lt on the first trial when requested.
    function automatic logic [2:0] cmp_flags(input logic [W-1:0] a, input logic [W-1:0] t,
                                             input logic frc);
        if (frc && t == TOP) return 3'b011;
        return {a == t, a > t, a < t};
    endfunction

    always_comb {if0.cmp_eq, if0.cmp_gt, if0.cmp_lt} = cmp_flags(a_val[0], if0.trial, force_first[0]);
    always_comb {if2.cmp_eq, if2.cmp_gt, if2.cmp_lt} = cmp_flags(a_val[1], if2.trial, force_first[1]);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- search-level reference model ----------------
    logic [W-1:0] plan_trial [2][W];
    int           plan_steps [2];
    logic [W-1:0] plan_final [2];
    int           plan_err   [2];
    logic [W-1:0] m_prev     [2];
    bit           m_active   [2];
    int           s_edge     [2];
    int           ecount = 0;
    bit           chk_en = 0;

    // Binary search on the integer a: the list of trials, the final value, and the step of any flag error.
    task automatic make_plan(input int d);
        logic [W-1:0] v, t;
        bit keep;
        v = '0;
        plan_steps[d] = 0;
        plan_err[d]   = -1;
        for (int b = W - 1; b >= 0; b--) begin
            t = v | (W'(1) << b);
            plan_trial[d][plan_steps[d]] = t;
            plan_steps[d]++;
            if (force_first[d] && b == W - 1) begin
                plan_err[d] = 0;
                keep = 1'b0;
            end else begin
`ifdef SAR_EARLY_EXIT_EN
                if (a_val[d] == t) begin
                    v = t;
                    break;
                end
`endif
                keep = (a_val[d] >= t);
            end
            if (keep) v = t;
        end
        plan_final[d] = v;
    endtask

    function automatic int done_at(input int d);
        return plan_steps[d] * (1 + lat[d]) + 1;
    endfunction

    // At each edge, the model records resets and accepted starts. n counts cycles after the start edge, from 1.
    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                int n_end;
                if (rst) begin
                    m_active[d] = 0;
                    m_prev[d]   = '0;
                end else begin
                    n_end = ecount - s_edge[d] + 1;
                    if (start_r[d] && (!m_active[d] || n_end >= done_at(d))) begin
                        m_prev[d] = m_active[d] ? plan_final[d] : '0;
                        make_plan(d);
                        m_active[d] = 1;
                        s_edge[d]   = ecount + 1;
                    end
                end
            end
            ecount++;
        end
    end

    // Compare every output of both instances with the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [W-1:0] e_trial, e_result;
                logic e_busy, e_done, e_err;
                int n, per;
                e_trial = '0; e_result = '0; e_busy = 0; e_done = 0; e_err = 0;
                if (m_active[d]) begin
                    per = 1 + lat[d];
                    n   = ecount - s_edge[d] + 1;
                    if (n < done_at(d)) begin
                        e_trial  = plan_trial[d][(n - 1) / per];
                        e_busy   = 1;
                        e_result = m_prev[d];
                    end else begin
                        e_trial  = plan_final[d];
                        e_result = plan_final[d];
                        e_done   = (n == done_at(d));
                    end
                    e_err = (plan_err[d] >= 0) && (n >= (plan_err[d] + 1) * per + 1);
                end
                check($sformatf("d%0d trial", d),  32'(trial_o[d]),  32'(e_trial));
                check($sformatf("d%0d result", d), 32'(result_o[d]), 32'(e_result));
                check($sformatf("d%0d busy", d),   32'(busy_o[d]),   32'(e_busy));
                check($sformatf("d%0d done", d),   32'(done_o[d]),   32'(e_done));
                check($sformatf("d%0d err", d),    32'(err_o[d]),    32'(e_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] trace [$];
    int           r_busy, r_done;
    logic [W-1:0] r_res;
    logic         r_err, r_err_first;

    // Run one search on instance d. With now=1, start is driven in the current cycle (used from a DONE cycle).
    // With poke=1, a second start is issued while the search is busy; it must be ignored.
    task automatic do_search(input int d, input logic [W-1:0] a, input bit frc,
                             input bit now, input bit poke);
        bit seen_done;
        if (!now) @(negedge clk);
        a_val[d]       = a;
        force_first[d] = frc;
        start_r[d]     = 1'b1;
        @(negedge clk);
        start_r[d] = 1'b0;
        trace.delete();
        r_busy = 0; r_done = -1; seen_done = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0) r_err_first = err_o[d];
            if (busy_o[d]) begin
                r_busy++;
                if (trace.size() == 0 || trace[$] != trial_o[d]) trace.push_back(trial_o[d]);
            end
            if (done_o[d]) begin
                r_done = i + 1;
                r_res  = result_o[d];
                r_err  = err_o[d];
                seen_done = 1;
                break;
            end
            start_r[d] = (poke && i == 0);
            @(negedge clk);
        end
        start_r[d] = 1'b0;
        force_first[d] = 1'b0;
        if (!seen_done) check($sformatf("d%0d done within budget", d), 0, 1);
    endtask

    task automatic check_trace(input string name, input logic [4*W-1:0] exp, input int cnt);
        check({name, " trial count"}, trace.size(), cnt);
        for (int i = 0; i < cnt && i < trace.size(); i++)
            check($sformatf("%s trial %0d", name, i), 32'(trace[i]), 32'(exp[4*W-1-W*i -: W]));
    endtask

    initial begin
        start_r[0] = 0; start_r[1] = 0;
        a_val[0] = '0; a_val[1] = '0;
        force_first[0] = 0; force_first[1] = 0;
        m_active[0] = 0; m_active[1] = 0;
        s_edge[0] = 0; s_edge[1] = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset trial", 32'(trial_o[0]), 0);
        check("reset busy",  32'(busy_o[0]), 0);
        rst = 1'b0;

        // a=1011: trials 1000,1100,1010,1011, done in cycle 5.
        do_search(0, 4'b1011, 0, 0, 0);
        check_trace("a1011", {4'b1000, 4'b1100, 4'b1010, 4'b1011}, 4);
        check("a1011 result", 32'(r_res), 32'hB);
        check("a1011 done cycle", r_done, 5);
        check("a1011 busy cycles", r_busy, 4);
        check("a1011 err", 32'(r_err), 0);

        // a=0, then a=15 started in the DONE cycle.
        do_search(0, 4'b0000, 0, 0, 0);
        check_trace("a0", {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4);
        check("a0 result", 32'(r_res), 0);
        do_search(0, 4'b1111, 0, 1, 0);
        check_trace("a15", {4'b1000, 4'b1100, 4'b1110, 4'b1111}, 4);
        check("a15 result", 32'(r_res), 32'hF);
        check("a15 done cycle", r_done, 5);

        // a=1000: the early-exit build stops after one trial.
        do_search(0, 4'b1000, 0, 0, 0);
        check("a1000 result", 32'(r_res), 32'h8);
`ifdef SAR_EARLY_EXIT_EN
        check_trace("a1000", {4'b1000, 12'b0}, 1);
        check("a1000 done cycle", r_done, 2);
`else
        check_trace("a1000", {4'b1000, 4'b1100, 4'b1010, 4'b1001}, 4);
        check("a1000 done cycle", r_done, 5);
`endif

        // CMP_LAT=2, a=0110: each trial held 3 cycles, busy for 12 cycles.
        do_search(1, 4'b0110, 0, 0, 0);
        check_trace("lat2 a0110", {4'b1000, 4'b0100, 4'b0110, 4'b0111}, 4);
        check("lat2 result", 32'(r_res), 32'h6);
        check("lat2 busy cycles", r_busy, 12);
        check("lat2 done cycle", r_done, 13);

        // Illegal flags on the first sample: MSB cleared, err sticky, cleared by next start.
        do_search(0, 4'b1011, 1, 0, 0);
        check("forced result", 32'(r_res), 32'h7);
        check("forced err at done", 32'(r_err), 1);
        @(negedge clk);
        check("forced err held", 32'(err_o[0]), 1);
        do_search(0, 4'b1011, 0, 0, 0);
        check("err cleared by start", 32'(r_err_first), 0);
        check("after err result", 32'(r_res), 32'hB);

        // Reset two cycles into a search.
        @(negedge clk);
        a_val[0] = 4'b0101;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 32'(busy_o[0]), 0);
        check("rst trial", 32'(trial_o[0]), 0);
        check("rst result", 32'(result_o[0]), 0);
        check("rst done", 32'(done_o[0]), 0);
        repeat (6) @(negedge clk);
        do_search(0, 4'b0101, 0, 0, 0);
        check("post-rst result", 32'(r_res), 32'h5);

        // Random searches: random a, instance, forced flags, ignored starts and idle gaps.
        for (int it = 0; it < 40; it++) begin
            int d;
            logic [W-1:0] a;
            d = $urandom_range(0, 1);
            a = W'($urandom_range(0, (1 << W) - 1));
            do_search(d, a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
